// File: rtl/cache_pkg.sv
// Shared geometry and FSM encoding for the direct-mapped write-through data cache.
// Everything else derives its field widths from the three base sizes below.
package cache_pkg;

    localparam int WORD_SIZE  = 16;
    localparam int NUM_LINES  = 4;
    localparam int LINE_WORDS = 4;

    localparam int OFFSET_W  = $clog2(LINE_WORDS);
    localparam int INDEX_W   = $clog2(NUM_LINES);
    localparam int TAG_W     = WORD_SIZE - OFFSET_W - INDEX_W;
    localparam int LINE_BITS = WORD_SIZE * LINE_WORDS;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2
    } state_t;

    // Word address of the first word of the line holding addr.
    function automatic logic [WORD_SIZE-1:0] line_base(input logic [WORD_SIZE-1:0] addr);
        return {addr[WORD_SIZE-1:OFFSET_W], {OFFSET_W{1'b0}}};
    endfunction

endpackage

// File: rtl/cache_line_array.sv
// Valid/tag/data storage for the data cache: combinational lookup of one line,
// whole-line install on fill and single-word update on write hit.
module cache_line_array
    import cache_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [INDEX_W-1:0]   index,
    input  logic [TAG_W-1:0]     tag,
    input  logic [OFFSET_W-1:0]  offset,
    output logic                 hit,
    output logic [WORD_SIZE-1:0] word,
    input  logic                 line_we,
    input  logic [LINE_BITS-1:0] line_data,
    input  logic                 word_we,
    input  logic [WORD_SIZE-1:0] word_data
);

    logic                 valid_reg [NUM_LINES];
    logic [TAG_W-1:0]     tag_reg   [NUM_LINES];
    logic [WORD_SIZE-1:0] data_reg  [NUM_LINES][LINE_WORDS];

    assign hit  = valid_reg[index] && (tag_reg[index] == tag);
    assign word = data_reg[index][offset];

    for (genvar gi = 0; gi < NUM_LINES; gi++) begin : g_line
        localparam logic [INDEX_W-1:0] LINE_ID = INDEX_W'(gi);

        // Only the valid bits are cleared; stale tags/data are harmless once invalid.
        always_ff @(posedge clk) begin
            if (reset) begin
                valid_reg[gi] <= 1'b0;
            end else if (line_we && index == LINE_ID) begin
                valid_reg[gi] <= 1'b1;
            end
        end

        always_ff @(posedge clk) begin
            if (line_we && index == LINE_ID) begin
                tag_reg[gi] <= tag;
            end
        end

        for (genvar gw = 0; gw < LINE_WORDS; gw++) begin : g_word
            localparam logic [OFFSET_W-1:0] WORD_ID = OFFSET_W'(gw);

            always_ff @(posedge clk) begin
                if (line_we && index == LINE_ID) begin
                    data_reg[gi][gw] <= line_data[gw*WORD_SIZE +: WORD_SIZE];
                end else if (word_we && index == LINE_ID && offset == WORD_ID) begin
                    data_reg[gi][gw] <= word_data;
                end
            end
        end
    end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-through, write-no-allocate data cache: same-cycle read hits,
// line fills on read miss, every write forwarded to memory; hit/miss counters.
module data_cache
    import cache_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cpu_read,
    input  logic                 cpu_write,
    input  logic [WORD_SIZE-1:0] cpu_address,
    input  logic [WORD_SIZE-1:0] cpu_wdata,
    output logic [WORD_SIZE-1:0] cpu_rdata,
    output logic                 cpu_ready,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic [WORD_SIZE-1:0] mem_address,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic [LINE_BITS-1:0] mem_rdata,
    input  logic                 mem_ready,
    output logic [WORD_SIZE-1:0] hit_count,
    output logic [WORD_SIZE-1:0] miss_count
);

    state_t state_reg, state_next;

    logic [WORD_SIZE-1:0] hit_count_reg, miss_count_reg;
    logic                 count_hit, count_miss;

    logic [TAG_W-1:0]    addr_tag;
    logic [INDEX_W-1:0]  addr_index;
    logic [OFFSET_W-1:0] addr_offset;

    logic                 lookup_hit;
    logic [WORD_SIZE-1:0] lookup_word;
    logic                 line_we, word_we;

    logic [WORD_SIZE-1:0] fill_word [LINE_WORDS];

    assign addr_offset = cpu_address[OFFSET_W-1:0];
    assign addr_index  = cpu_address[OFFSET_W +: INDEX_W];
    assign addr_tag    = cpu_address[WORD_SIZE-1 -: TAG_W];

    for (genvar gi = 0; gi < LINE_WORDS; gi++) begin : g_fill_word
        assign fill_word[gi] = mem_rdata[gi*WORD_SIZE +: WORD_SIZE];
    end

    cache_line_array u_lines (
        .clk       (clk),
        .reset     (reset),
        .index     (addr_index),
        .tag       (addr_tag),
        .offset    (addr_offset),
        .hit       (lookup_hit),
        .word      (lookup_word),
        .line_we   (line_we),
        .line_data (mem_rdata),
        .word_we   (word_we),
        .word_data (cpu_wdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        cpu_ready   = 1'b0;
        cpu_rdata   = lookup_word;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_address = cpu_address;
        mem_wdata   = cpu_wdata;
        line_we     = 1'b0;
        word_we     = 1'b0;
        count_hit   = 1'b0;
        count_miss  = 1'b0;

        case (state_reg)
            IDLE: begin
                // Write wins over a simultaneous read request.
                if (cpu_write) begin
                    state_next = WRITE;
                end else if (cpu_read) begin
                    if (lookup_hit) begin
                        cpu_ready = 1'b1;
                        count_hit = 1'b1;
                    end else begin
                        state_next = FILL;
                    end
                end
            end

            FILL: begin
                mem_read    = 1'b1;
                mem_address = line_base(cpu_address);
                if (mem_ready) begin
                    line_we    = 1'b1;
                    cpu_ready  = 1'b1;
                    cpu_rdata  = fill_word[addr_offset];
                    count_miss = 1'b1;
                    state_next = IDLE;
                end
            end

            WRITE: begin
                mem_write = 1'b1;
                if (mem_ready) begin
                    cpu_ready  = 1'b1;
                    word_we    = lookup_hit;
                    count_hit  = lookup_hit;
                    count_miss = !lookup_hit;
                    state_next = IDLE;
                end
            end

            default: state_next = IDLE;
        endcase

        if (reset) begin
            state_next = IDLE;
            cpu_ready  = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            line_we    = 1'b0;
            word_we    = 1'b0;
            count_hit  = 1'b0;
            count_miss = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hit_count_reg  <= '0;
            miss_count_reg <= '0;
        end else begin
            if (count_hit) begin
                hit_count_reg <= hit_count_reg + WORD_SIZE'(1);
            end
            if (count_miss) begin
                miss_count_reg <= miss_count_reg + WORD_SIZE'(1);
            end
        end
    end

    assign hit_count  = hit_count_reg;
    assign miss_count = miss_count_reg;

endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench for data_cache: multi-cycle memory with programmable latency,
// flat-memory plus resident-line reference model, directed and random transactions.
module tb_data_cache;
    import cache_pkg::*;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 cpu_read = 1'b0, cpu_write = 1'b0;
    logic [15:0]          cpu_address = '0, cpu_wdata = '0;
    logic [15:0]          cpu_rdata;
    logic                 cpu_ready;
    logic                 mem_read, mem_write;
    logic [15:0]          mem_address, mem_wdata;
    logic [LINE_BITS-1:0] mem_rdata = '0;
    logic                 mem_ready = 1'b0;
    logic [15:0]          hit_count, miss_count;

    data_cache dut (
        .clk         (clk),
        .reset       (reset),
        .cpu_read    (cpu_read),
        .cpu_write   (cpu_write),
        .cpu_address (cpu_address),
        .cpu_wdata   (cpu_wdata),
        .cpu_rdata   (cpu_rdata),
        .cpu_ready   (cpu_ready),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_address (mem_address),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ready   (mem_ready)
        ,.hit_count  (hit_count),
        .miss_count  (miss_count)
    );

    always #5 clk = ~clk;

    // Environment memory and reference model state.
    logic [15:0] mem     [0:65535];
    logic [15:0] ref_mem [0:65535];
    bit          ref_valid [4];
    logic [13:0] ref_line  [4];
    logic [15:0] exp_hit = '0, exp_miss = '0;

    int  checks = 0, errors = 0;
    int  cur_lat = 2;
    int  mem_cnt = 0;
    bit  started = 0;
    bit  desync = 0;
    logic [15:0] last_rdata;
    int  last_cycles;
    int  txn_no = 0;

    task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    function automatic bit model_hit(input logic [15:0] a);
        return ref_valid[a[3:2]] && ref_line[a[3:2]] == a[15:2];
    endfunction

    // Memory: mem_ready rises on the cur_lat-th cycle of a request; aborts reset the count.
    always @(posedge clk) begin
        #2;
        if ((mem_read || mem_write) && !reset) begin
            mem_cnt++;
            mem_ready = (mem_cnt >= cur_lat);
        end else begin
            mem_cnt   = 0;
            mem_ready = 1'b0;
        end
        for (int k = 0; k < 4; k++) begin
            mem_rdata[k*16 +: 16] = mem[{mem_address[15:2], 2'(k)}];
        end
    end

    // A write handshake seen here is certain to complete on the coming edge.
    always @(negedge clk) begin
        if (mem_write && mem_ready && !reset) begin
            mem[mem_address] = mem_wdata;
        end
    end

    // Continuous compare: counters against the model, read/write exclusivity.
    always @(negedge clk) begin
        if (started && !reset) begin
            check_eq("mem_rw_overlap", 64'(mem_read & mem_write), 64'(0));
            check_eq("hit_count", 64'(hit_count), 64'(exp_hit));
            check_eq("miss_count", 64'(miss_count), 64'(exp_miss));
        end
    end

    task automatic do_reset(input int n);
        reset = 1'b1;
        cpu_read = 1'b0;
        cpu_write = 1'b0;
        exp_hit = '0;
        exp_miss = '0;
        for (int i = 0; i < 4; i++) ref_valid[i] = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_eq("reset_outputs", 64'({cpu_ready, mem_read, mem_write}), 64'(0));
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
    endtask

    // Entered and left at posedge+1; request cycle is cycle 0.
    task automatic do_txn(input bit is_write, input logic [15:0] addr, input logic [15:0] wdata,
                          input int lat);
        bit hit;
        bit done;
        int k;
        hit = model_hit(addr);
        k = (!is_write && hit) ? 0 : lat;
        cur_lat = lat;
        desync = 0;
        done = 0;
        cpu_address = addr;
        cpu_wdata = wdata;
        cpu_write = is_write;
        cpu_read = !is_write;
        for (int c = 0; c <= k + 16 && !done; c++) begin
            @(negedge clk);
            if (c > 0 && c <= k) begin
                if (is_write)
                    check_eq("mem_write_req", {30'd0, mem_read, mem_write, mem_address, mem_wdata},
                             {30'd0, 2'b01, addr, wdata});
                else
                    check_eq("mem_fill_req", {46'd0, mem_read, mem_write, mem_address},
                             {46'd0, 2'b10, addr[15:2], 2'b00});
            end
            if (c < k) begin
                check_eq("early_ready", 64'(cpu_ready), 64'(0));
                if (c == 0) check_eq("idle_no_mem", 64'({mem_read, mem_write}), 64'(0));
                if (cpu_ready) begin
                    desync = 1;
                    done = 1;
                end
            end else if (c == k) begin
                check_eq("ready", 64'(cpu_ready), 64'(1));
                if (k == 0) check_eq("hit_no_mem", 64'({mem_read, mem_write}), 64'(0));
                if (cpu_ready) begin
                    done = 1;
                    if (!is_write) check_eq("rdata", 64'(cpu_rdata), 64'(ref_mem[addr]));
                end else begin
                    desync = 1;
                end
            end else if (cpu_ready) begin
                done = 1;
            end
            last_rdata = cpu_rdata;
            last_cycles = c;
            if (!done) begin
                @(posedge clk);
                #1;
            end
        end
        if (!done) check_eq("ready_timeout", 64'(cpu_ready), 64'(1));
        $display("txn %0d %s addr=%04h wdata=%04h lat=%0d model=%s cycles=%0d rdata=%04h",
                 txn_no, is_write ? "WR" : "RD", addr, wdata, lat, hit ? "hit" : "miss",
                 last_cycles, last_rdata);
        txn_no++;
        @(posedge clk);
        if (!desync) begin
            if (hit) exp_hit++;
            else exp_miss++;
            if (is_write) begin
                ref_mem[addr] = wdata;
            end else if (!hit) begin
                ref_valid[addr[3:2]] = 1;
                ref_line[addr[3:2]] = addr[15:2];
            end
        end
        #1;
        cpu_read = 1'b0;
        cpu_write = 1'b0;
        if (desync) do_reset(2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] a, d;
        for (int i = 0; i < 65536; i++) begin
            mem[i] = 16'(i * 40503) ^ 16'h5A5A;
        end
        mem[16'h0010] = 16'hABCD;
        mem[16'h0013] = 16'h1357;
        for (int i = 0; i < 65536; i++) ref_mem[i] = mem[i];

        @(posedge clk);
        #1;
        do_reset(3);
        started = 1;
        @(negedge clk);
        check_eq("lit_reset_counts", 64'({hit_count, miss_count}), 64'(0));
        @(posedge clk);
        #1;

        // Cold read miss with memory latency 2.
        do_txn(0, 16'h0010, 16'h0000, 2);
        check_eq("lit_fill_rdata", 64'(last_rdata), 64'(16'hABCD));
        check_eq("lit_fill_cycle", 64'(last_cycles), 64'(2));
        check_eq("lit_miss_1", 64'(miss_count), 64'(1));

        do_txn(0, 16'h0013, 16'h0000, 2);
        check_eq("lit_hit_rdata", 64'(last_rdata), 64'(16'h1357));
        check_eq("lit_hit_cycle", 64'(last_cycles), 64'(0));
        check_eq("lit_hit_1", 64'(hit_count), 64'(1));

        do_txn(1, 16'h0011, 16'h1234, 2);
        do_txn(0, 16'h0011, 16'h0000, 2);
        check_eq("lit_wr_hit_rdata", 64'(last_rdata), 64'(16'h1234));
        check_eq("lit_hit_3", 64'(hit_count), 64'(3));

        // Write miss must reach memory without allocating.
        do_txn(1, 16'h0040, 16'h5555, 3);
        check_eq("lit_mem_0040", 64'(mem[16'h0040]), 64'(16'h5555));
        check_eq("lit_miss_2", 64'(miss_count), 64'(2));
        do_txn(0, 16'h0040, 16'h0000, 2);
        check_eq("lit_wr_miss_rdata", 64'(last_rdata), 64'(16'h5555));
        check_eq("lit_miss_3", 64'(miss_count), 64'(3));

        // Same index, different tags: every access refills.
        do_txn(0, 16'h0010, 16'h0000, 1);
        do_txn(0, 16'h0110, 16'h0000, 1);
        do_txn(0, 16'h0010, 16'h0000, 1);
        check_eq("lit_conflict_rdata", 64'(last_rdata), 64'(16'hABCD));
        check_eq("lit_miss_6", 64'(miss_count), 64'(6));

        for (int n = 0; n < 300; n++) begin
            a = 16'($urandom_range(0, 3) * 256 + $urandom_range(0, 31));
            d = 16'($urandom);
            do_txn($urandom_range(0, 9) < 4, a, d, int'($urandom_range(1, 4)));
            if ($urandom_range(0, 7) == 0) begin
                @(posedge clk);
                #1;
            end
        end

        // Reset in the middle of a fill abandons it and invalidates the cache.
        cur_lat = 3;
        cpu_address = 16'h0F20;
        cpu_read = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        check_eq("abort_fill_active", 64'(mem_read), 64'(1));
        @(posedge clk);
        #1;
        reset = 1'b1;
        exp_hit = '0;
        exp_miss = '0;
        for (int i = 0; i < 4; i++) ref_valid[i] = 0;
        @(negedge clk);
        check_eq("abort_forced_low", 64'({cpu_ready, mem_read, mem_write}), 64'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        cpu_read = 1'b0;
        @(negedge clk);
        check_eq("abort_mem_read", 64'(mem_read), 64'(0));
        check_eq("lit_abort_counts", 64'({hit_count, miss_count}), 64'(0));
        @(posedge clk);
        #1;
        do_txn(0, 16'h0F20, 16'h0000, 2);
        check_eq("lit_reread_cycle", 64'(last_cycles), 64'(2));
        check_eq("lit_reread_miss", 64'(miss_count), 64'(1));

        started = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
